prim_sky130_ram_1p_banked: RTL
==============================

Name: prim_sky130_ram_1p_banked

Overview:
- Generalised single-port RAM built from sky130_sram_2kbyte_1rw1r_32x512_8 macros (32 bits x 512 words, byte write mask, 1-cycle read).
- Macros are tiled as NumCols = Width/32 column slices by NumBanks = Depth/512 banks.
- Adds a registered read-bank select, a read-valid pipeline, a grant handshake and a post-reset zero-initialisation sequencer.
- Sits under the prim_ram_1p abstraction; used by SoC SRAM and ROM-shadow memories.

Parameters:
- Width, 32, data width in bits; must be a multiple of 32 and in the range 32..128.
- Depth, 2048, number of words; must be 512 * 2^k, with k in 0..4.
- DataBitsPerMask, 1, accepted for interface compatibility only; byte masking is fixed by the macro.
- MemInitFile, "", ignored; the sky130 macro cannot be preloaded.
- Aw, $clog2(Depth), localparam, address width.
- NumBanks, Depth/512, localparam.
- NumCols, Width/32, localparam.
- BankAw, $clog2(NumBanks), localparam; 0 means a single bank.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  access request
- gnt_o  out  1  request accepted this cycle
- write_i  in  1  1 = write, 0 = read
- addr_i  in  Aw  word address
- wdata_i  in  Width  write data
- wmask_i  in  Width  bit write mask
- rdata_o  out  Width  read data; valid only while rvalid_o = 1
- rvalid_o  out  1  read data valid, one cycle after a granted read
- init_done_o  out  1  initialisation complete
- cfg_i  in  ram_1p_cfg_t  unused; kept for prim compatibility

Behaviour:
- Reset: clk_i single clock; rst_ni is asynchronous assert, active-low.
  - Reset values: gnt_o = 0, rvalid_o = 0, init_done_o = 0, bank register = 0, init counter = 0, rdata_o = 0.
- Address split:
  - Bank index = addr_i[Aw-1 -: BankAw]; row = addr_i[8:0].
  - With NumBanks = 1, bank index is constant 0.
- Byte mask: for each macro, macro wmask bit j = AND of wmask_i[32c+8j+7 : 32c+8j].
  - A partially set byte is not written.
- Macro controls:
  - csb0 is low only for the selected bank, on a granted request or an init write.
  - All column slices of a bank share csb0, web0 and addr0.
- FSM states:
  - INIT: entered on reset release. Writes all-zero data with full mask to row = counter, in every bank simultaneously. Counter runs 0..511; after row 511 is written, go to READY.
  - READY: gnt_o = req_i combinationally. Remain here until reset.
- init_done_o and gnt_o:
  - init_done_o = 1 only in READY.
  - gnt_o = 0 throughout INIT; requests seen during INIT are ignored, not queued.
- Read latency is 1:
  - A granted read in cycle N gives rvalid_o = 1 in cycle N+1.
  - rdata_o comes from the bank sampled in cycle N (registered bank select, never the live addr_i).
- Writes: take effect at the clock edge of the granted cycle; rvalid_o stays 0.
- Back-to-back reads to different banks, one per cycle: each result is routed through its own registered bank index.
- Read-after-write to the same address in consecutive cycles returns the new data.
- rdata_o when rvalid_o = 0: driven 0 (output gated by rvalid_o).
- Reset mid-INIT or mid-read: restarts INIT from row 0; a pending rvalid_o is dropped.
- Elaboration: a Width/Depth outside the legal set triggers $error.

Optional Feature:
- Macro name: PRIM_SKY130_RAM_ZEROIZE_EN.
- Defined: INIT sequencing as described above; ready 512 cycles after reset release.
- Undefined:
  - FSM reset state is READY, and init_done_o = 1 from the first cycle after reset release.
  - The counter and the INIT datapath are not built.
  - Memory contents after power-up are undefined.

Decomposition:
- prim_ram_1p_pkg holds:
  - ram_1p_cfg_t (existing).
  - New constants: Sky130MacroWidth = 32, Sky130MacroDepth = 512, Sky130MacroMaskW = 4.
  - ram_init_state_e {RamInit, RamReady}.
- Sub-module prim_sky130_ram_bank: one bank of NumCols macros.
  - Performs byte-mask reduction.
  - Exposes a Width-wide din/dout plus csb/web/addr.
  - The top level contains the FSM, the bank decode and the read mux.

Test Plan:
1. Reset, ZEROIZE_EN defined:
   - gnt_o = 0 and init_done_o = 0 for 512 cycles after rst_ni release, then init_done_o = 1.
   - A read of address 0x7FF then returns 0x00000000.
2. Width = 32, Depth = 2048:
   - Write 0xDEADBEEF to 0x000, 0x200, 0x400 and 0x600 (one per bank).
   - Read them back-to-back, one per cycle.
   - Four consecutive rvalid_o pulses, each returning 0xDEADBEEF from the correct bank.
   - Then write 0x11111111 to 0x200 only; reads of 0x000 and 0x200 return 0xDEADBEEF and 0x11111111.
3. Byte mask:
   - Write 0xAABBCCDD to 0x010 with mask 0xFFFFFFFF, then write 0x11223344 with mask 0x00FF00F0.
   - Read returns 0xAA22CCDD; the 0xF0 partial byte is not written.
4. Width = 64, Depth = 512 (single bank, two columns):
   - Write 0x0123456789ABCDEF to 0x1FF; read gives that value with rvalid_o one cycle later.
5. During INIT, hold req_i = 1 with a write to 0x005:
   - gnt_o stays 0 and no write occurs.
   - After init_done_o = 1, reading 0x005 returns 0.
6. Assert rst_ni low in the cycle after a granted read:
   - rvalid_o = 0 immediately (asynchronous reset).
   - INIT restarts at row 0.

Source files
------------

// File: rtl/prim_ram_1p_pkg.sv
// Shared types and sky130 macro geometry for the single-port RAM primitives.
package prim_ram_1p_pkg;

   typedef struct packed {
      logic       ram_cfg_en;
      logic [3:0] ram_cfg;
      logic       rf_cfg_en;
      logic [3:0] rf_cfg;
   } ram_1p_cfg_t;

   localparam int Sky130MacroWidth = 32;
   localparam int Sky130MacroDepth = 512;
   localparam int Sky130MacroMaskW = 4;

   typedef enum logic {
      RamInit,
      RamReady
   } ram_init_state_e;

endpackage

// File: rtl/prim_sky130_ram_bank.sv
// One bank of sky130 macros side by side; reduces the bit mask to the macro's
// byte mask (a byte is written only when all eight of its mask bits are set).
module prim_sky130_ram_bank
   import prim_ram_1p_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic                                  clk_i,
   input  logic                                  csb_i,
   input  logic                                  web_i,
   input  logic [$clog2(Sky130MacroDepth)-1:0]   addr_i,
   input  logic [Width-1:0]                      wmask_i,
   input  logic [Width-1:0]                      din_i,
   output logic [Width-1:0]                      dout_o
);

   localparam int NumCols = Width / Sky130MacroWidth;

   for (genvar c = 0; c < NumCols; c++) begin : gen_col
      logic [Sky130MacroMaskW-1:0] byte_mask;
      logic [Sky130MacroWidth-1:0] unused_dout1;

      always_comb begin
         byte_mask = '0;
         for (int unsigned j = 0; j < Sky130MacroMaskW; j++) begin
            byte_mask[j] = &wmask_i[c*Sky130MacroWidth + 8*j +: 8];
         end
      end

      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
         .clk0   (clk_i),
         .csb0   (csb_i),
         .web0   (web_i),
         .wmask0 (byte_mask),
         .addr0  (addr_i),
         .din0   (din_i[c*Sky130MacroWidth +: Sky130MacroWidth]),
         .dout0  (dout_o[c*Sky130MacroWidth +: Sky130MacroWidth]),
         .clk1   (clk_i),
         .csb1   (1'b1),
         .addr1  ('0),
         .dout1  (unused_dout1)
      );
   end

endmodule

// File: rtl/sky130_sram_2kbyte_1rw1r_32x512_8.sv
// Behavioural stand-in for the sky130 OpenRAM 32x512 1rw1r macro: active-low
// chip/write enables, byte write mask, read data registered on the clock edge.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
   input  logic        clk0,
   input  logic        csb0,
   input  logic        web0,
   input  logic [3:0]  wmask0,
   input  logic [8:0]  addr0,
   input  logic [31:0] din0,
   output logic [31:0] dout0,
   input  logic        clk1,
   input  logic        csb1,
   input  logic [8:0]  addr1,
   output logic [31:0] dout1
);

   logic [31:0] mem [512];

   always_ff @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end
         end else begin
            dout0 <= mem[addr0];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!csb1) dout1 <= mem[addr1];
   end

endmodule

// File: rtl/prim_sky130_ram_1p_banked.sv
// Single-port RAM tiled from sky130 32x512 macros with registered read-bank select.
// Define PRIM_SKY130_RAM_ZEROIZE_EN to zero all rows after reset before granting.
module prim_sky130_ram_1p_banked
   import prim_ram_1p_pkg::*;
#(
   parameter int Width           = 32,
   parameter int Depth           = 2048,
   parameter int DataBitsPerMask = 1,
   parameter     MemInitFile     = "",
   localparam int Aw             = $clog2(Depth)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic              write_i,
   input  logic [Aw-1:0]     addr_i,
   input  logic [Width-1:0]  wdata_i,
   input  logic [Width-1:0]  wmask_i,
   output logic [Width-1:0]  rdata_o,
   output logic              rvalid_o,
   output logic              init_done_o,
   input  ram_1p_cfg_t       cfg_i
);

   localparam int NumBanks = Depth / Sky130MacroDepth;
   localparam int NumCols  = Width / Sky130MacroWidth;
   localparam int BankAw   = $clog2(NumBanks);
   localparam int BankW    = (BankAw > 0) ? BankAw : 1;
   localparam int RowAw    = $clog2(Sky130MacroDepth);

   localparam bit LegalWidth = (Width >= 32) && (Width <= 128) &&
                               (NumCols * Sky130MacroWidth == Width);
   localparam bit LegalDepth = (NumBanks >= 1) && (NumBanks <= 16) &&
                               (NumBanks * Sky130MacroDepth == Depth) &&
                               ((NumBanks & (NumBanks - 1)) == 0);

   if (!LegalWidth || !LegalDepth) begin : gen_bad_cfg
      $error("prim_sky130_ram_1p_banked: unsupported Width/Depth");
   end

   localparam int    unused_dbpm = DataBitsPerMask;
   localparam string unused_mif  = MemInitFile;
   logic unused_cfg;
   assign unused_cfg = ^cfg_i;

   ram_init_state_e   state_q, state_d;
   logic              ready;
   logic              init_we;
   logic              mem_web;
   logic [RowAw-1:0]  mem_row;
   logic [Width-1:0]  mem_din;
   logic [Width-1:0]  mem_wmask;

`ifdef PRIM_SKY130_RAM_ZEROIZE_EN
   logic [RowAw-1:0] init_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= RamInit;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 init_cnt_q <= '0;
      else if (state_q == RamInit) init_cnt_q <= init_cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == RamInit && init_cnt_q == '1) state_d = RamReady;
   end

   // init_we is gated by rst_ni so the macros are not written while reset is held.
   always_comb begin
      ready       = rst_ni && (state_q == RamReady);
      init_we     = rst_ni && (state_q == RamInit);
      init_done_o = ready;
      gnt_o       = ready && req_i;
   end

   assign mem_web   = init_we ? 1'b0 : ~write_i;
   assign mem_row   = init_we ? init_cnt_q : addr_i[RowAw-1:0];
   assign mem_din   = init_we ? '0 : wdata_i;
   assign mem_wmask = init_we ? '1 : wmask_i;
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= RamReady;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
   end

   always_comb begin
      ready       = rst_ni && (state_q == RamReady);
      init_we     = 1'b0;
      init_done_o = ready;
      gnt_o       = ready && req_i;
   end

   assign mem_web   = ~write_i;
   assign mem_row   = addr_i[RowAw-1:0];
   assign mem_din   = wdata_i;
   assign mem_wmask = wmask_i;
`endif

   logic [BankW-1:0] bank_sel, bank_q;
   logic             rd_fire, rvalid_q;

   if (BankAw > 0) begin : gen_bank_sel
      assign bank_sel = addr_i[Aw-1 -: BankAw];
   end else begin : gen_single_bank
      assign bank_sel = '0;
   end

   // Padded to a power of two so bank_q can index it directly for any bank count.
   logic [Width-1:0] bank_dout [1 << BankW];

   for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
      logic csb;
      assign csb = ~((gnt_o && (bank_sel == BankW'(b))) || init_we);

      prim_sky130_ram_bank #(
         .Width (Width)
      ) u_bank (
         .clk_i   (clk_i),
         .csb_i   (csb),
         .web_i   (mem_web),
         .addr_i  (mem_row),
         .wmask_i (mem_wmask),
         .din_i   (mem_din),
         .dout_o  (bank_dout[b])
      );
   end

   for (genvar p = NumBanks; p < (1 << BankW); p++) begin : gen_pad
      assign bank_dout[p] = '0;
   end

   assign rd_fire = gnt_o && !write_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         bank_q   <= '0;
      end else begin
         rvalid_q <= rd_fire;
         if (rd_fire) bank_q <= bank_sel;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rvalid_q ? bank_dout[bank_q] : '0;

endmodule
